// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample width, I2S serializer states and
// WM8731 clock ratios (18.432 MHz MCLK, 3.072 MHz BCLK, 48 kHz LRC).
package audio_pkg;
  localparam int SAMPLE_W      = 16;
  localparam int MCLK_PER_BCLK = 6;
  localparam int BCLK_PER_LRC  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2,
    PAD   = 2'd3
  } i2s_state_t;
endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO with show-ahead head word and full/empty flags.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int N     = SAMPLE_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: rtl/dac_serializer.sv
// I2S serializer feeding a WM8731 DAC: mono samples duplicated to both channels.
// Define DAC_SERIALIZER_HOLD_LAST_EN to replay the last sample on underrun.
module dac_serializer
  import audio_pkg::*;
#(
  parameter int N     = SAMPLE_W,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic signed [N-1:0] sample_data,
  input  logic                valid,
  output logic                ready,
  input  logic                bclk,
  input  logic                daclrc,
  output logic                dacdat,
  output logic                underrun
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  logic bclk_p0, bclk_p1, bclk_p2;
  logic lrc_p0, lrc_p1, lrc_p2;
  logic bclk_fall, lrc_fall, lrc_rise;

  logic                run_q;
  logic                fifo_full, fifo_empty;
  logic [N-1:0]        fifo_dout;
  logic                fifo_pop;

  i2s_state_t          state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic signed [N-1:0] shreg_q;
  logic signed [N-1:0] word_q;
  logic signed [N-1:0] hold_word;
  logic signed [N-1:0] load_word;
  logic                load_l, load_r, drive_bit, pad_go;

  // Stage p0/p1: synchronisers; p2: edge-detect history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {bclk_p0, bclk_p1, bclk_p2} <= '0;
      {lrc_p0, lrc_p1, lrc_p2}    <= '0;
    end else begin
      {bclk_p0, bclk_p1, bclk_p2} <= {bclk, bclk_p0, bclk_p1};
      {lrc_p0, lrc_p1, lrc_p2}    <= {daclrc, lrc_p0, lrc_p1};
    end
  end

  assign bclk_fall = bclk_p2 & ~bclk_p1;
  assign lrc_fall  = lrc_p2 & ~lrc_p1;
  assign lrc_rise  = ~lrc_p2 & lrc_p1;

  assign ready    = run_q & ~fifo_full;
  assign fifo_pop = load_l & ~fifo_empty;

  sample_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (valid & ready),
    .pop   (fifo_pop),
    .din   (sample_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef DAC_SERIALIZER_HOLD_LAST_EN
  logic signed [N-1:0] hold_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      hold_q <= '0;
    else if (fifo_pop) hold_q <= $signed(fifo_dout);
  end
  assign hold_word = hold_q;
`else
  assign hold_word = '0;
`endif

  // Left frames take the FIFO head (or the underrun word); right frames repeat it
  assign load_word = load_r ? word_q : (fifo_empty ? hold_word : $signed(fifo_dout));

  always_comb begin
    state_d   = state_q;
    load_l    = 1'b0;
    load_r    = 1'b0;
    drive_bit = 1'b0;
    pad_go    = 1'b0;
    case (state_q)
      IDLE: begin
        if (lrc_fall) begin
          load_l  = 1'b1;
          state_d = DELAY;
        end
      end
      default: begin
        if (lrc_fall || lrc_rise) begin
          load_l  = lrc_fall;
          load_r  = lrc_rise;
          state_d = DELAY;
        end else if (bclk_fall) begin
          if (state_q == SHIFT && cnt_q == N_CNT) begin
            pad_go  = 1'b1;
            state_d = PAD;
          end else if (state_q != PAD) begin
            drive_bit = 1'b1;
            state_d   = SHIFT;
          end
        end
      end
    endcase
  end

  // Stage p3: FSM, shift register and serial output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q    <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      dacdat   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      run_q    <= 1'b1;
      state_q  <= state_d;
      underrun <= load_l & fifo_empty;
      if (load_l || load_r) begin
        shreg_q <= load_word;
        cnt_q   <= '0;
        dacdat  <= 1'b0;
      end else if (drive_bit) begin
        dacdat  <= shreg_q[N-1];
        shreg_q <= {shreg_q[N-2:0], 1'b0};
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end else if (pad_go) begin
        dacdat <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_l) word_q <= load_word;
  end
endmodule

// File: tb/tb_dac_serializer.sv
// Randomized bench for dac_serializer against a frame-level I2S reference model.
module tb_dac_serializer;
  localparam int N     = 16;
  localparam int DEPTH = 4;
  localparam int HALF  = 56;

  logic                clk = 1'b0;
  logic                reset_n = 1'b1;
  logic signed [N-1:0] sample_data = '0;
  logic                valid = 1'b0;
  logic                ready;
  logic                bclk = 1'b1;
  logic                daclrc = 1'b1;
  logic                dacdat;
  logic                underrun;

  int n_tests = 0;
  int n_fail  = 0;
  int underrun_cnt = 0;
  int exp_underrun = 0;

  logic [N-1:0] q[$];
  logic [N-1:0] last_pop = '0;
  logic [N-1:0] cur_word = '0;
  bit           started = 1'b0;
  bit           stream_on = 1'b0;

  always #5 clk = ~clk;

  dac_serializer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_data (sample_data),
    .valid       (valid),
    .ready       (ready),
    .bclk        (bclk),
    .daclrc      (daclrc),
    .dacdat      (dacdat),
    .underrun    (underrun)
  );

  always @(negedge clk) if (underrun) underrun_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
    end
  endtask

  task automatic push_once(input logic [N-1:0] d, output bit acc);
    @(negedge clk);
    sample_data = d;
    valid = 1'b1;
    acc = ready;
    if (acc) q.push_back(d);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic left_load();
    if (q.size() > 0) begin
      cur_word = q.pop_front();
      last_pop = cur_word;
    end else begin
      exp_underrun++;
`ifdef DAC_SERIALIZER_HOLD_LAST_EN
      cur_word = last_pop;
`else
      cur_word = '0;
`endif
    end
    started = 1'b1;
  endtask

  // One stereo frame of 2*L bclk periods; dacdat sampled at each bclk rise
  task automatic run_frame(input int L, input int rst_at, input string tag);
    for (int h = 0; h < 2; h++) begin
      logic [63:0] got_v;
      logic [63:0] exp_v;
      bit e;
      got_v = '0;
      exp_v = '0;
      for (int k = 0; k < L; k++) begin
        bclk = 1'b0;
        if (k == 0) begin
          daclrc = (h == 1);
          if (h == 0) left_load();
        end
        if (h == 0 && k == rst_at) begin
          #2 reset_n = 1'b0;
          #1;
          check("rst_dacdat", dacdat, 0);
          check("rst_ready", ready, 0);
          #29 reset_n = 1'b1;
          q.delete();
          last_pop = '0;
          started = 1'b0;
          #(HALF - 32);
        end else begin
          #(HALF);
        end
        e = (started && k >= 1 && k <= N) ? cur_word[N-k] : 1'b0;
        got_v = {got_v[62:0], dacdat};
        exp_v = {exp_v[62:0], e};
        bclk = 1'b1;
        #(HALF);
      end
      check({tag, (h == 0) ? "_L" : "_R"}, got_v, exp_v);
    end
  endtask

  task automatic producer();
    while (stream_on) begin
      @(negedge clk);
      if (stream_on && q.size() < 3 && $urandom_range(0, 1) == 1) begin
        sample_data = N'($urandom);
        valid = 1'b1;
        check("rdy_lvl", ready, 1);
        if (ready) q.push_back(sample_data);
      end else begin
        valid = 1'b0;
      end
    end
    valid = 1'b0;
  endtask

  initial begin
    bit acc;
    logic [N-1:0] s;

    #2 reset_n = 1'b0;
    #1;
    check("reset_dacdat", dacdat, 0);
    check("reset_underrun", underrun, 0);
    check("reset_ready", ready, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1 check("ready_pre", ready, 0);
    @(negedge clk);
    check("ready_rise", ready, 1);
    repeat (6) @(negedge clk);

    // Single known word in both channels
    push_once(16'hA5C3, acc);
    check("push_a5c3", acc, 1);
    @(negedge clk);
    run_frame(32, -1, "a5c3");
    check("underrun_a5c3", underrun_cnt, exp_underrun);

    // Fill to full with no frames running, then drain in order
    for (int i = 0; i < 5; i++) begin
      s = N'($urandom);
      push_once(s, acc);
      check("fill_acc", acc, (i < DEPTH) ? 1 : 0);
    end
    check("ready_full", ready, 0);
    @(negedge clk);
    repeat (4) run_frame(32, -1, "drain");
    check("underrun_drain", underrun_cnt, exp_underrun);

    // Underrun after a pop of 16'h7FFF
    push_once(16'h7FFF, acc);
    @(negedge clk);
    run_frame(32, -1, "max");
    repeat (2) run_frame(32, -1, "empty");
    check("underrun_empty", underrun_cnt, exp_underrun);
    check("underrun_two", exp_underrun, 2);

    // Reset mid-SHIFT, then recovery at next left frame
    push_once(N'($urandom), acc);
    @(negedge clk);
    run_frame(32, 6, "rst");
    push_once(N'($urandom), acc);
    check("post_rst_acc", acc, 1);
    @(negedge clk);
    run_frame(32, -1, "post_rst");
    check("underrun_rst", underrun_cnt, exp_underrun);

    // Short frames truncate the word
    push_once(N'($urandom), acc);
    push_once(N'($urandom), acc);
    @(negedge clk);
    run_frame(8, -1, "short");
    run_frame(8, -1, "short");
    push_once(N'($urandom), acc);
    @(negedge clk);
    run_frame(32, -1, "after_short");
    check("underrun_short", underrun_cnt, exp_underrun);

    // Streaming with concurrent push and pop
    push_once(N'($urandom), acc);
    push_once(N'($urandom), acc);
    @(negedge clk);
    stream_on = 1'b1;
    fork
      begin
        repeat (5) run_frame(32, -1, "stream");
        stream_on = 1'b0;
      end
      producer();
    join
    check("underrun_stream", underrun_cnt, exp_underrun);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
